// File: rtl/sargantana_itag_array_param.sv
// Instruction-cache tag array: N_WAY ways x DEPTH sets of TAG_W-bit tags plus valid bits, with tag compare.
// Latency: reads return tag/valid one cycle after acceptance; hit is combinational from the registered read data.
// Backpressure: ready_o drops for exactly DEPTH cycles while a flush walks every set; requests and flush_i are ignored then.
//
// Optional feature: define ITAG_PARITY_EN to store an even-parity bit per tag entry and flag corrupted valid entries.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   req_i[N_WAY]           per-way access enable (any bit set = request)
//   we_i, vbit_i, data_i   write strobe, valid bit and tag to write
//   flush_i                one-cycle pulse starting invalidation of all sets
//   addr_i, cmp_tag_i      set index, lookup tag (captured on reads)
//   ready_o                block accepts requests
//   tag_way_o, vbit_o      registered read tags and valid bits per way
//   hit_way_o, hit_o       per-way hit and OR of all ways
//   parity_err_o           per-way parity error on the last read (0 without ITAG_PARITY_EN)

module sargantana_itag_array_param #(
  parameter int unsigned N_WAY = 4,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned TAG_W = 27,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [N_WAY-1:0]            req_i,
  input  logic                        we_i,
  input  logic                        vbit_i,
  input  logic                        flush_i,
  input  logic [TAG_W-1:0]            data_i,
  input  logic [AW-1:0]               addr_i,
  input  logic [TAG_W-1:0]            cmp_tag_i,
  output logic                        ready_o,
  output logic [N_WAY-1:0][TAG_W-1:0] tag_way_o,
  output logic [N_WAY-1:0]            vbit_o,
  output logic [N_WAY-1:0]            hit_way_o,
  output logic                        hit_o,
  output logic [N_WAY-1:0]            parity_err_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]                         flush_cnt;
  logic [N_WAY-1:0][DEPTH-1:0]           vld_mem;
  logic [N_WAY-1:0][DEPTH-1:0][TAG_W-1:0] tag_mem;
  logic [TAG_W-1:0]                      cmp_q;

  logic accept;
  logic rd_en;
  logic wr_en;
  logic flush_start;
  logic flush_last;

  // Flush has priority: a request arriving with flush_i is dropped.
  assign flush_start = (state == IDLE) && flush_i;
  assign accept      = ready_o && (|req_i) && !flush_i;
  assign rd_en       = accept && !we_i;
  assign wr_en       = accept && we_i;
  assign flush_last  = (state == FLUSH) && (flush_cnt == AW'(DEPTH - 1));

  // ---------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush_i)    state_nxt = FLUSH;
      FLUSH:   if (flush_last) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
  end

  // Flush walk index: one set per cycle, back to 0 after the last set.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      flush_cnt <= '0;
    end else if (state == FLUSH) begin
      flush_cnt <= flush_last ? '0 : flush_cnt + AW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Storage. Valid bits are flops with reset; tags are never reset
  // and never touched by a flush.
  // ---------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_mem <= '0;
    end else if (state == FLUSH) begin
      for (int w = 0; w < N_WAY; w++) begin
        vld_mem[w][flush_cnt] <= 1'b0;
      end
    end else if (wr_en) begin
      for (int w = 0; w < N_WAY; w++) begin
        if (req_i[w]) vld_mem[w][addr_i] <= vbit_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int w = 0; w < N_WAY; w++) begin
        if (req_i[w]) tag_mem[w][addr_i] <= data_i;
      end
    end
  end

  // ---------------------------------------------------------------
  // Read port. Unrequested ways keep their last read value; writes
  // leave the read registers alone.
  // ---------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tag_way_o <= '0;
      vbit_o    <= '0;
      cmp_q     <= '0;
    end else if (flush_start) begin
      vbit_o <= '0;
    end else if (rd_en) begin
      cmp_q <= cmp_tag_i;
      for (int w = 0; w < N_WAY; w++) begin
        if (req_i[w]) begin
          tag_way_o[w] <= tag_mem[w][addr_i];
          vbit_o[w]    <= vld_mem[w][addr_i];
        end
      end
    end
  end

`ifdef ITAG_PARITY_EN
  // Even parity: stored bit equals XOR of the tag, so tag^parity is 0 when intact.
  logic [N_WAY-1:0][DEPTH-1:0] par_mem;
  logic [N_WAY-1:0]            perr_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int w = 0; w < N_WAY; w++) begin
        if (req_i[w]) par_mem[w][addr_i] <= ^data_i;
      end
    end
  end

  // Only valid entries report errors; the flag holds until the way is read again.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perr_q <= '0;
    end else if (flush_start) begin
      perr_q <= '0;
    end else if (rd_en) begin
      for (int w = 0; w < N_WAY; w++) begin
        if (req_i[w]) begin
          perr_q[w] <= vld_mem[w][addr_i] &&
                       ((^tag_mem[w][addr_i]) != par_mem[w][addr_i]);
        end
      end
    end
  end

  assign parity_err_o = perr_q;
`else
  assign parity_err_o = '0;
`endif

  // Hit from registered values only; a parity-flagged way never hits.
  always_comb begin
    hit_way_o = '0;
    for (int w = 0; w < N_WAY; w++) begin
      hit_way_o[w] = vbit_o[w] && (tag_way_o[w] == cmp_q) && !parity_err_o[w];
    end
  end

  assign hit_o = |hit_way_o;

endmodule

// File: tb/tb_sargantana_itag_array_param.sv
module tb_sargantana_itag_array_param;

  localparam int N  = 4;
  localparam int D  = 128;
  localparam int T  = 27;
  localparam int AW = 7;

  logic                clk = 1'b0;
  logic                rstn_i;
  logic [N-1:0]        req_i;
  logic                we_i;
  logic                vbit_i;
  logic                flush_i;
  logic [T-1:0]        data_i;
  logic [AW-1:0]       addr_i;
  logic [T-1:0]        cmp_tag_i;
  logic                ready_o;
  logic [N-1:0][T-1:0] tag_way_o;
  logic [N-1:0]        vbit_o;
  logic [N-1:0]        hit_way_o;
  logic                hit_o;
  logic [N-1:0]        parity_err_o;

  sargantana_itag_array_param #(.N_WAY(N), .DEPTH(D), .TAG_W(T)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .req_i        (req_i),
    .we_i         (we_i),
    .vbit_i       (vbit_i),
    .flush_i      (flush_i),
    .data_i       (data_i),
    .addr_i       (addr_i),
    .cmp_tag_i    (cmp_tag_i),
    .ready_o      (ready_o),
    .tag_way_o    (tag_way_o),
    .vbit_o       (vbit_o),
    .hit_way_o    (hit_way_o),
    .hit_o        (hit_o),
    .parity_err_o (parity_err_o)
  );

  initial forever #5 clk = ~clk;

  // Reference model: storage contents plus what the read registers should show.
  logic [T-1:0] m_tag   [N][D];
  bit           m_vld   [N][D];
  bit           m_known [N][D];
  bit           m_bad   [N][D];
  logic [T-1:0] exp_tag   [N];
  bit           exp_known [N];
  bit           exp_vbit  [N];
  bit           exp_perr  [N];
  logic [T-1:0] exp_cmp;
  int           flush_left;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < N; w++) begin
      for (int s = 0; s < D; s++) m_vld[w][s] = 1'b0;
      exp_tag[w]   = '0;
      exp_known[w] = 1'b1;
      exp_vbit[w]  = 1'b0;
      exp_perr[w]  = 1'b0;
    end
    exp_cmp    = '0;
    flush_left = 0;
  endtask

  task automatic check_all(input string where);
    logic [N-1:0] ev, eh, ep;
    ev = '0; eh = '0; ep = '0;
    for (int w = 0; w < N; w++) begin
      ev[w] = exp_vbit[w];
      ep[w] = exp_perr[w];
      eh[w] = exp_vbit[w] && exp_known[w] && (exp_tag[w] == exp_cmp) && !exp_perr[w];
    end
    chk({where, ":ready"},    64'(ready_o),      64'(flush_left == 0));
    chk({where, ":vbit"},     64'(vbit_o),       64'(ev));
    chk({where, ":hit_way"},  64'(hit_way_o),    64'(eh));
    chk({where, ":hit"},      64'(hit_o),        64'(|eh));
    chk({where, ":par_err"},  64'(parity_err_o), 64'(ep));
    for (int w = 0; w < N; w++) begin
      if (exp_known[w]) chk($sformatf("%s:tag%0d", where, w), 64'(tag_way_o[w]), 64'(exp_tag[w]));
    end
  endtask

  // Apply the current inputs for one clock edge, update the model, then check.
  task automatic cycle(input string where);
    if (flush_left > 0) begin
      flush_left--;
    end else if (flush_i) begin
      flush_left = D;
      for (int w = 0; w < N; w++) begin
        for (int s = 0; s < D; s++) m_vld[w][s] = 1'b0;
        exp_vbit[w] = 1'b0;
        exp_perr[w] = 1'b0;
      end
    end else if (req_i != '0) begin
      if (we_i) begin
        for (int w = 0; w < N; w++) if (req_i[w]) begin
          m_tag[w][addr_i]   = data_i;
          m_vld[w][addr_i]   = vbit_i;
          m_known[w][addr_i] = 1'b1;
          m_bad[w][addr_i]   = 1'b0;
        end
      end else begin
        exp_cmp = cmp_tag_i;
        for (int w = 0; w < N; w++) if (req_i[w]) begin
          exp_tag[w]   = m_tag[w][addr_i];
          exp_known[w] = m_known[w][addr_i];
          exp_vbit[w]  = m_vld[w][addr_i];
          exp_perr[w]  = m_vld[w][addr_i] && m_bad[w][addr_i];
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic w, input logic v, input logic [T-1:0] d,
                       input logic [AW-1:0] a, input logic [T-1:0] c, input logic f);
    req_i = r; we_i = w; vbit_i = v; data_i = d; addr_i = a; cmp_tag_i = c; flush_i = f;
  endtask

  logic [T-1:0] t_a, t_b;
  int           busy;
  logic [N-1:0][T-1:0] prev_tags;

  initial begin
    rstn_i = 1'b0;
    drive('0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int w = 0; w < N; w++)
      for (int s = 0; s < D; s++) begin
        m_known[w][s] = 1'b0;
        m_bad[w][s]   = 1'b0;
      end
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rstn_i = 1'b1;
    cycle("post_reset");

    // Read of an untouched set after reset: nothing valid, no hit.
    drive(4'b1111, 1'b0, 1'b0, '0, 7'd5, '0, 1'b0);
    cycle("rd_set5");

    // Single-way write then read-after-write hit.
    drive(4'b0100, 1'b1, 1'b1, 27'h1ABCDEF, 7'd10, '0, 1'b0);
    cycle("wr_set10");
    drive(4'b1111, 1'b0, 1'b0, '0, 7'd10, 27'h1ABCDEF, 1'b0);
    cycle("rd_set10");
    chk("hit_way_set10", 64'(hit_way_o), 64'(4'b0100));
    chk("hit_set10",     64'(hit_o),     64'(1'b1));

    // Partial-way read: untouched ways keep what set 3 produced.
    for (int w = 0; w < N; w++) begin
      drive(4'(1 << w), 1'b1, 1'b1, T'($urandom), 7'd3, '0, 1'b0);
      cycle("wr_set3");
    end
    drive(4'b1111, 1'b0, 1'b0, '0, 7'd3, '0, 1'b0);
    cycle("rd_set3_all");
    prev_tags = tag_way_o;
    drive(4'b0001, 1'b0, 1'b0, '0, 7'd10, '0, 1'b0);
    cycle("rd_set10_w0");
    for (int w = 1; w < N; w++)
      chk($sformatf("hold_tag%0d", w), 64'(tag_way_o[w]), 64'(m_tag[w][3]));

    // Fill sets 0 and 127, then flush with a simultaneous read.
    for (int s = 0; s < 2; s++) begin
      drive(4'b1111, 1'b1, 1'b1, T'($urandom), s == 0 ? 7'd0 : 7'd127, '0, 1'b0);
      cycle("fill");
    end
    drive(4'b1111, 1'b0, 1'b0, '0, 7'd0, m_tag[0][0], 1'b1);
    cycle("flush_start");
    busy = (ready_o == 1'b0) ? 1 : 0;
    for (int i = 0; i < D + 8 && ready_o == 1'b0; i++) begin
      // Garbage requests and repeat flushes must be ignored.
      drive(4'($urandom), 1'($urandom), 1'b1, T'($urandom), AW'($urandom), '0, 1'($urandom));
      cycle("flushing");
      if (ready_o == 1'b0) busy++;
    end
    chk("flush_len", 64'(busy), 64'(D));
    drive(4'b1111, 1'b0, 1'b0, '0, 7'd0, '0, 1'b0);
    cycle("rd_set0_after_flush");
    drive(4'b1111, 1'b0, 1'b0, '0, 7'd127, '0, 1'b0);
    cycle("rd_set127_after_flush");

    // Reset in the middle of a flush.
    drive(4'b1111, 1'b1, 1'b1, T'($urandom), 7'd50, '0, 1'b0);
    cycle("wr_set50");
    drive('0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    cycle("flush2_start");
    flush_i = 1'b0;
    for (int i = 0; i < 40; i++) cycle("flush2");
    rstn_i = 1'b0;
    model_reset();
    #2;
    check_all("mid_flush_reset");
    chk("vld_mem_clear", 64'(|dut.vld_mem), 64'(0));
    @(negedge clk);
    rstn_i = 1'b1;
    cycle("release2");
    drive(4'b1111, 1'b0, 1'b0, '0, 7'd50, m_tag[0][50], 1'b0);
    cycle("rd_set50_after_reset");

    // Randomized traffic over a small set range so hits are common.
    for (int i = 0; i < 400; i++) begin
      int w;
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 7));
      w = $urandom_range(0, N - 1);
      t_a = T'($urandom);
      t_b = (m_known[w][a] && $urandom_range(0, 3) != 0) ? m_tag[w][a] : T'($urandom);
      drive(4'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
            t_a, a, t_b, ($urandom_range(0, 149) == 0));
      cycle("random");
    end
    drive('0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < D + 2 && flush_left > 0; i++) cycle("drain");

`ifdef ITAG_PARITY_EN
    // Corrupt one stored tag bit on way 1 and read it back with the original tag.
    t_a = 27'h0123456;
    drive(4'b0010, 1'b1, 1'b1, t_a, 7'd20, '0, 1'b0);
    cycle("par_wr");
    if (dut.tag_mem[1][20][3]) force dut.tag_mem[1][20][3] = 1'b0;
    else                       force dut.tag_mem[1][20][3] = 1'b1;
    m_tag[1][20] = t_a ^ 27'h8;
    m_bad[1][20] = 1'b1;
    drive(4'b1111, 1'b0, 1'b0, '0, 7'd20, t_a, 1'b0);
    cycle("par_rd");
    chk("par_err_vec", 64'(parity_err_o), 64'(4'b0010));
    chk("par_hit_w1",  64'(hit_way_o[1]), 64'(1'b0));
    release dut.tag_mem[1][20][3];
    drive(4'b0010, 1'b1, 1'b1, t_a, 7'd20, '0, 1'b0);
    cycle("par_rewrite");
    drive(4'b0010, 1'b0, 1'b0, '0, 7'd20, t_a, 1'b0);
    cycle("par_reread");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sargantana_itag_array_param.md
SARGANTANA_ITAG_ARRAY_PARAM -- requirements
Module: sargantana_itag_array_param

Interface
REQ-001 SHALL have parameter N_WAY, default 4: number of ways, 1..8.
REQ-002 SHALL have parameter DEPTH, default 128: sets per way, a power of two from 2 to 1024.
REQ-003 SHALL have parameter TAG_W, default 27: tag width in bits.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports named clk_i and rstn_i.
REQ-005 Port: clk_i, in, 1, rising-edge clock.
REQ-006 Port: rstn_i, in, 1, asynchronous active-low reset.
REQ-007 Port: req_i, in, N_WAY, per-way access enable.
REQ-008 Port: we_i, in, 1, 1 = write, 0 = read.
REQ-009 Port: vbit_i, in, 1, valid bit value to write.
REQ-010 Port: flush_i, in, 1, single-cycle pulse that starts invalidation of all sets.
REQ-011 Port: data_i, in, TAG_W, tag to write.
REQ-012 Port: addr_i, in, $clog2(DEPTH), set index.
REQ-013 Port: cmp_tag_i, in, TAG_W, lookup tag, sampled with a read.
REQ-014 Port: ready_o, out, 1, block accepts requests.
REQ-015 Port: tag_way_o, out, N_WAY x TAG_W, read tags.
REQ-016 Port: vbit_o, out, N_WAY, read valid bits.
REQ-017 Port: hit_way_o, out, N_WAY, per-way hit.
REQ-018 Port: hit_o, out, 1, OR of hit_way_o.
REQ-019 Port: parity_err_o, out, N_WAY, per-way tag parity error.

Function
REQ-020 Request accept rule: a request is accepted only when ready_o=1 and |req_i=1; when ready_o=0, req_i, we_i and flush_i SHALL be ignored.
REQ-021 Read (we_i=0): 1-cycle latency; at cycle N+1, tag_way_o[w] and vbit_o[w] SHALL show the contents of set addr_i for each requested way; unrequested ways hold their previous values.
REQ-022 Compare tag: cmp_tag_i SHALL be registered on every accepted read.
REQ-023 Hit outputs: hit_way_o[w] = vbit_o[w] & (tag_way_o[w] == registered cmp tag), computed combinationally from registered values; hit_o = |hit_way_o.
REQ-024 Write (we_i=1): the tag and valid bit of every requested way at addr_i SHALL update at the clock edge; tag_way_o and vbit_o SHALL be unchanged.
REQ-025 Read-after-write: a read of the same set and way in the following cycle SHALL return the newly written tag and valid bit.
REQ-026 FSM states: IDLE (ready_o=1) and FLUSH (ready_o=0).
REQ-027 IDLE->FLUSH: taken when flush_i=1; flush SHALL win over a request in the same cycle, and that request SHALL be dropped.
REQ-028 Flush start: at entry to FLUSH, vbit_o and hit_way_o SHALL clear to 0.
REQ-029 FLUSH walk: an index counter starts at 0 and clears the valid bits of all ways at one set per cycle.
REQ-030 FLUSH->IDLE: after the cycle that clears set DEPTH-1; the flush therefore lasts exactly DEPTH cycles, with ready_o=1 in the cycle after.
REQ-031 flush_i during FLUSH SHALL be ignored (no restart).
REQ-032 Tag storage SHALL NOT be altered by a flush.

Reset
REQ-033 While rstn_i=0, asynchronously: all valid bits=0, FSM=IDLE, flush counter=0, and tag_way_o, vbit_o, hit_way_o, parity_err_o all 0.
REQ-034 After reset release, ready_o SHALL be 1 and hit_o SHALL be 0.
REQ-035 Tag storage SHALL NOT be reset.
REQ-036 Reset asserted mid-flush SHALL abort the flush, leaving all valid bits 0.

Configuration
REQ-037 Macro ITAG_PARITY_EN, when defined: store one even-parity bit per tag entry, written with the tag.
REQ-038 With ITAG_PARITY_EN defined, on a read, a parity mismatch on a way whose valid bit is 1 SHALL set parity_err_o[w] in cycle N+1 and force hit_way_o[w]=0.
REQ-039 With ITAG_PARITY_EN defined, parity_err_o[w] SHALL hold until the next accepted read of way w, a flush start, or reset.
REQ-040 With ITAG_PARITY_EN undefined: no parity storage, and parity_err_o tied to 0.

Verification
REQ-041 Reset release, then read all ways of set 5 -> vbit_o=0000, hit_o=0, ready_o=1.
REQ-042 Write tag 0x1ABCDEF with vbit_i=1 to way 2, set 10; read set 10 next cycle with cmp_tag_i=0x1ABCDEF -> hit_way_o=0100, hit_o=1.
REQ-043 Fill set 0 and set 127; pulse flush_i together with a read request -> read dropped; ready_o=0 for exactly 128 cycles; then reads of sets 0 and 127 give vbit_o=0000 with tags unchanged.
REQ-044 Assert rstn_i at flush cycle 40 -> FSM=IDLE and ready_o=1 after release, and all valid bits 0.
REQ-045 With ITAG_PARITY_EN: flip one stored tag bit via force on way 1, then read with a matching cmp tag -> parity_err_o=0010, hit_way_o[1]=0.
REQ-046 Read way 0 only after an earlier read of all ways -> tag_way_o[1..3] hold their earlier values.
